// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// port index constants and default bus widths.
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between an
// instruction-fetch read port and a data load/store port; one access per 3 cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic [DATA_W-1:0] rdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic [DATA_W-1:0] rdata1,
   output logic              ack1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   arb_state_e        state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic              wr_q, wr_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              elig0, elig1, pick;

   // A port acked this cycle still holds req; masking it avoids serving it twice.
   always_comb begin
      elig0 = req0 & ~ack0_q;
      elig1 = req1 & ~ack1_q;
      if (elig0 && elig1) begin
         pick = ~last_grant_q;
      end else begin
         pick = elig1 ? PORT_DATA : PORT_FETCH;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      wr_d         = wr_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      mem_en_d     = mem_en_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (elig0 || elig1) begin
               state_d      = ST_ACCESS;
               grant_d      = pick;
               last_grant_d = pick;
               mem_en_d     = 1'b1;
               if (pick == PORT_DATA) begin
                  wr_d        = we1;
                  mem_we_d    = we1;
                  mem_addr_d  = addr1;
                  mem_wdata_d = wdata1;
               end else begin
                  wr_d        = 1'b0;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = addr0;
                  mem_wdata_d = '0;
               end
            end
         end
         ST_ACCESS: begin
            state_d  = ST_DONE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (grant_q == PORT_DATA) begin
               ack1_d = 1'b1;
               if (!wr_q) begin
                  rdata1_d = mem_rdata;
               end
            end else begin
               ack0_d   = 1'b1;
               rdata0_d = mem_rdata;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= PORT_FETCH;
         last_grant_q <= PORT_DATA;
         wr_q         <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         wr_q         <= wr_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign rdata0    = rdata0_q;
   assign ack0      = ack0_q;
   assign rdata1    = rdata1_q;
   assign ack1      = ack1_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a synchronous memory slave, a transaction-level
// reference model compared every cycle, and directed literal scenarios.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata1;
   logic [DW-1:0] rdata0, rdata1;
   logic          ack0, ack1;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_on  = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .rdata0(rdata0), .ack0(ack0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .rdata1(rdata1), .ack1(ack1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Memory slave: read data appears the cycle after the command is sampled.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   bit            mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         mem[16'h0010] <= 32'hDEADBEEF;
         mem_init      <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   // Reference model: a grant issues a one-cycle command, the ack follows two
   // edges after the grant and carries the memory contents seen at grant time.
   logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
   int            m_since;
   logic          m_last, m_port, m_wr;
   logic          m_ack0, m_ack1, m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_exp, m_rd0, m_rd1;
   logic          m_e0, m_e1, m_pick;

   assign m_e0   = req0 && !m_ack0;
   assign m_e1   = req1 && !m_ack1;
   assign m_pick = (m_e0 && m_e1) ? !m_last : m_e1;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_since <= 0;
         m_last  <= 1'b1;
         m_port  <= 1'b0;
         m_wr    <= 1'b0;
         m_ack0  <= 1'b0;
         m_ack1  <= 1'b0;
         m_en    <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_exp   <= '0;
         m_rd0   <= '0;
         m_rd1   <= '0;
         mdl_mem[16'h0010] <= 32'hDEADBEEF;
      end else begin
         m_ack0 <= 1'b0;
         m_ack1 <= 1'b0;
         if (m_since == 0) begin
            if (m_e0 || m_e1) begin
               m_since <= 1;
               m_last  <= m_pick;
               m_port  <= m_pick;
               m_en    <= 1'b1;
               if (m_pick) begin
                  m_we    <= we1;
                  m_wr    <= we1;
                  m_addr  <= addr1;
                  m_wdata <= wdata1;
                  m_exp   <= mdl_mem[addr1];
                  if (we1) mdl_mem[addr1] <= wdata1;
               end else begin
                  m_we    <= 1'b0;
                  m_wr    <= 1'b0;
                  m_addr  <= addr0;
                  m_wdata <= '0;
                  m_exp   <= mdl_mem[addr0];
               end
            end
         end else if (m_since == 1) begin
            m_since <= 2;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
         end else begin
            m_since <= 0;
            if (m_port) begin
               m_ack1 <= 1'b1;
               if (!m_wr) m_rd1 <= m_exp;
            end else begin
               m_ack0 <= 1'b1;
               m_rd0  <= m_exp;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !reset) begin
         chk1("cmp_ack0", ack0, m_ack0);
         chk1("cmp_ack1", ack1, m_ack1);
         chk1("cmp_ack_excl", ack0 & ack1, 1'b0);
         chkd("cmp_rdata0", rdata0, m_rd0);
         chkd("cmp_rdata1", rdata1, m_rd1);
         chk1("cmp_mem_en", mem_en, m_en);
         chk1("cmp_mem_we", mem_we, m_we);
         chka("cmp_mem_addr", mem_addr, m_addr);
         chkd("cmp_mem_wdata", mem_wdata, m_wdata);
         chk1("cmp_busy", busy, m_since != 0);
      end
   end

   // Starts and ends on a falling edge; deasserts the request in the ack cycle.
   task automatic access(input bit port, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      bit ok;
      int n;
      if (!port) begin
         req0 = 1'b1; addr0 = a;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      end
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 20) begin
         @(negedge clk);
         n++;
         if (port ? ack1 : ack0) ok = 1'b1;
      end
      if (!port) req0 = 1'b0;
      else begin
         req1 = 1'b0; we1 = 1'b0;
      end
      chk1("access_ack_seen", ok, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ord [4];
      int tck [4];
      int cnt, n, extra, en_cnt;

      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata1 = '0;
      repeat (3) @(negedge clk);

      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_ack0", ack0, 1'b0);
      chk1("rst_ack1", ack1, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chka("rst_mem_addr", mem_addr, 16'h0000);
      chkd("rst_rdata0", rdata0, 32'h0);
      reset  = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);

      // Port-0 read of a preloaded word
      req0 = 1'b1; addr0 = 16'h0010;
      @(negedge clk);
      chk1("rd0_mem_en", mem_en, 1'b1);
      chka("rd0_mem_addr", mem_addr, 16'h0010);
      chk1("rd0_mem_we", mem_we, 1'b0);
      chk1("rd0_busy", busy, 1'b1);
      @(negedge clk);
      chk1("rd0_mem_en_off", mem_en, 1'b0);
      chk1("rd0_no_early_ack", ack0, 1'b0);
      @(negedge clk);
      chk1("rd0_ack", ack0, 1'b1);
      chkd("rd0_rdata", rdata0, 32'hDEADBEEF);
      req0 = 1'b0;
      @(negedge clk);
      chk1("rd0_ack_pulse", ack0, 1'b0);
      chkd("rd0_rdata_hold", rdata0, 32'hDEADBEEF);
      chk1("rd0_idle", busy, 1'b0);

      // Port-1 write, then port-0 readback
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 32'h12345678;
      @(negedge clk);
      chk1("wr1_mem_we", mem_we, 1'b1);
      chkd("wr1_mem_wdata", mem_wdata, 32'h12345678);
      @(negedge clk);
      chk1("wr1_mem_we_off", mem_we, 1'b0);
      @(negedge clk);
      chk1("wr1_ack", ack1, 1'b1);
      chkd("wr1_rdata1_unchanged", rdata1, 32'h0);
      req1 = 1'b0; we1 = 1'b0;
      @(negedge clk);
      access(1'b0, 1'b0, 16'h0020, 32'h0);
      chkd("wr1_readback", rdata0, 32'h12345678);
      @(negedge clk);

      // Both ports held from reset: alternate starting with port 0
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req0 = 1'b1; addr0 = 16'h0010;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
      cnt = 0; n = 0;
      while (cnt < 4 && n < 40) begin
         @(negedge clk);
         n++;
         if (ack0 || ack1) begin
            ord[cnt] = ack1 ? 1 : 0;
            tck[cnt] = cyc;
            cnt++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chki("rr_ack_count", cnt, 4);
      if (cnt == 4) begin
         chki("rr_order0", ord[0], 0);
         chki("rr_order1", ord[1], 1);
         chki("rr_order2", ord[2], 0);
         chki("rr_order3", ord[3], 1);
         chki("rr_gap1", tck[1] - tck[0], 3);
         chki("rr_gap3", tck[3] - tck[2], 3);
      end
      chkd("rr_rdata1", rdata1, 32'h12345678);
      repeat (3) @(negedge clk);

      // Port 0 held for three back-to-back accesses
      req0 = 1'b1; addr0 = 16'h0010;
      cnt = 0; n = 0; en_cnt = 0;
      while (cnt < 3 && n < 40) begin
         @(negedge clk);
         n++;
         if (mem_en) en_cnt++;
         if (ack0) begin
            tck[cnt] = cyc;
            cnt++;
         end
      end
      req0 = 1'b0;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack0) extra++;
         if (mem_en) en_cnt++;
      end
      chki("hold_ack_count", cnt + extra, 3);
      chki("hold_mem_en_cycles", en_cnt, 3);
      if (cnt == 3) chki("hold_gap", tck[1] - tck[0], 4);

      // Reset in the middle of an access
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
      @(negedge clk);
      chk1("mid_mem_en", mem_en, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk1("mid_rst_mem_en", mem_en, 1'b0);
      chka("mid_rst_mem_addr", mem_addr, 16'h0000);
      chk1("mid_rst_busy", busy, 1'b0);
      chkd("mid_rst_rdata0", rdata0, 32'h0);
      chkd("mid_rst_rdata1", rdata1, 32'h0);
      req1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack0 || ack1) extra++;
      end
      chki("mid_no_ack_after", extra, 0);
      access(1'b0, 1'b0, 16'h0010, 32'h0);
      chkd("mid_next_read", rdata0, 32'hDEADBEEF);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  port 0 (instruction fetch) read request, held until ack0.
REQ-006 addr0  input  ADDR_W  port 0 read address, stable while req0=1.
REQ-007 rdata0  output  DATA_W  port 0 read data, valid when ack0=1.
REQ-008 ack0  output  1  port 0 one-cycle completion pulse.
REQ-009 req1  input  1  port 1 (data load/store) request, held until ack1.
REQ-010 we1  input  1  port 1 write enable, stable while req1=1.
REQ-011 addr1  input  ADDR_W  port 1 address, stable while req1=1.
REQ-012 wdata1  input  DATA_W  port 1 write data, stable while req1=1.
REQ-013 rdata1  output  DATA_W  port 1 read data, valid when ack1=1 and access was a read.
REQ-014 ack1  output  1  port 1 one-cycle completion pulse.
REQ-015 mem_en, mem_we, mem_addr, mem_wdata  outputs  1/1/ADDR_W/DATA_W  registered single-port memory command.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; transitions IDLE->ACCESS on grant, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-019 In IDLE at a clock edge with an eligible request: latch granted port index, set mem_en=1, mem_addr=granted addr, mem_we=(port1 ? we1 : 0), mem_wdata=(port1 ? wdata1 : 0).
REQ-020 Leaving ACCESS: mem_en and mem_we cleared to 0; mem_addr and mem_wdata hold.
REQ-021 Leaving DONE: granted port's ack set to 1 for exactly one cycle; on a read its rdata register loads mem_rdata; on a write rdata1 holds its prior value.
REQ-022 Latency: request sampled at edge E0 -> ack visible after edge E2; peak throughput one access per 3 cycles.
REQ-023 Port 0 never writes: mem_we=0 for every port-0 access.
REQ-024 Arbitration: single requester wins; both requesting -> grant port != last_grant; last_grant updates on each grant.
REQ-025 A port whose ack is 1 in the current cycle is ineligible at that edge (prevents duplicate service of a held req).
REQ-026 rdata0/rdata1 hold their value between acks; ack0 and ack1 never both 1.
REQ-027 Requests arriving while busy=1 wait; no request is dropped while held.

Reset
REQ-028 Reset asynchronously forces: state=IDLE, last_grant=1 (port 0 wins first tie), ack0=ack1=0, rdata0=rdata1=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-access abandons the access: no ack is issued for it after reset release.

Structure
REQ-030 State encodings, port index constants (PORT_FETCH=0, PORT_DATA=1) and default widths live in the shared definitions include.
REQ-031 No sub-module; the 2-way round-robin pick is inlined.

Verification
REQ-032 req0=1, addr0=0x0010, mem holds 0xDEADBEEF -> mem_en one cycle with mem_addr=0x0010, ack0 pulse 2 edges later, rdata0=0xDEADBEEF.
REQ-033 req1=1, we1=1, addr1=0x0020, wdata1=0x12345678 -> mem_we=1, mem_wdata=0x12345678 one cycle, ack1 pulse, rdata1 unchanged; subsequent port-0 read of 0x0020 returns 0x12345678.
REQ-034 req0 and req1 both held after reset -> grant order 0,1,0,1; acks 3 cycles apart, never simultaneous.
REQ-035 req0 held continuously across 3 accesses -> exactly 3 ack0 pulses, no extra access in the ack cycle.
REQ-036 reset asserted in ACCESS state -> all outputs zero immediately (asynchronous), no ack after release, next request served normally.
